// File: rtl/mix_pkg.sv
// Shared types and constants for the mixing-round sequencer and its ALU.
package mix_pkg;

    localparam int unsigned N_LANES  = 8;
    localparam int unsigned N_STAGES = 7;

    // One entry per microprogram stage; the 3-bit encoding leaves one code unused.
    typedef enum logic [2:0] {
        S0,
        S1,
        S2,
        S3,
        S4,
        S5,
        S6
    } stage_t;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_t;

    // Final-stage multiplier and addend per lane; index 0 is the rightmost word.
    localparam logic [N_LANES-1:0][31:0] MA = {
        32'd19, 32'd17, 32'd13, 32'd11, 32'd7, 32'd5, 32'd3, 32'd2
    };
    localparam logic [N_LANES-1:0][31:0] MB = {
        32'd23, 32'd19, 32'd17, 32'd13, 32'd11, 32'd7, 32'd5, 32'd3
    };

endpackage

// File: rtl/mix_round_sequencer_if.sv
// Host-side bus of the mixing-round sequencer: lane write/read port, start and status.
interface mix_round_sequencer_if;

    logic        start;
    logic        wr_en;
    logic [2:0]  wr_idx;
    logic [31:0] wr_data;
    logic [2:0]  rd_idx;
    logic [31:0] rd_data;
    logic        busy;
    logic        done;

    // Host side.
    modport master (
        output start,
        output wr_en,
        output wr_idx,
        output wr_data,
        output rd_idx,
        input  rd_data,
        input  busy,
        input  done
    );

    // Sequencer side.
    modport slave (
        input  start,
        input  wr_en,
        input  wr_idx,
        input  wr_data,
        input  rd_idx,
        output rd_data,
        output busy,
        output done
    );

endinterface

// File: rtl/mix_alu.sv
// Combinational single-lane update for one micro-op of the mixing round.
// Operands are the current lane and its ring neighbours at the fixed offsets used by the stages.
module mix_alu
    import mix_pkg::*;
(
    input  stage_t      stage_i,
    input  logic [2:0]  idx_i,
    input  logic [31:0] l_i,
    input  logic [31:0] l_m2_i,
    input  logic [31:0] l_m1_i,
    input  logic [31:0] l_p1_i,
    input  logic [31:0] l_p2_i,
    input  logic [31:0] l_p3_i,
    input  logic [31:0] l_p4_i,
    input  logic [31:0] l_p5_i,
    output logic [31:0] l_o
);

    // Select the stage formula; all arithmetic wraps at 32 bits, shifts are logical.
    always_comb begin
        l_o = l_i;
        case (stage_i)
            S0:      l_o = l_i + {29'd0, idx_i};
            S1:      l_o = l_i + l_m1_i;
            S2:      l_o = l_i + l_p1_i - l_p5_i;
            S3:      l_o = l_i ^ (l_p3_i << 16);
            S4:      l_o = l_i - (l_p2_i >> 17) + (l_p4_i >> 12);
            S5:      l_o = l_i + l_m1_i - l_m2_i;
            S6:      l_o = (l_i * MA[idx_i]) + MB[idx_i];
            default: l_o = l_i;
        endcase
    end

endmodule

// File: rtl/mix_round_sequencer.sv
// Multi-cycle mixing-round controller: owns the eight-lane register file and steps one
// lane update per cycle through a shared combinational ALU, ROUNDS full rounds per start.
module mix_round_sequencer
    import mix_pkg::*;
#(
    parameter int unsigned ROUNDS = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    mix_round_sequencer_if.slave bus
);

    localparam stage_t     LastStage = stage_t'(3'(N_STAGES - 1));
    localparam logic [7:0] LastRound = 8'(ROUNDS - 1);

    state_t      state_q, state_d;
    stage_t      stage_q, stage_d;
    logic [2:0]  lane_idx_q, lane_idx_d;
    logic [7:0]  round_q, round_d;
    logic [31:0] lane_q [N_LANES];
    logic [31:0] lane_d [N_LANES];

    logic        last_op;
    logic [2:0]  idx_m2, idx_m1, idx_p1, idx_p2, idx_p3, idx_p4, idx_p5;
    logic [31:0] alu_out;

    // Ring neighbours of the active lane; 3-bit arithmetic gives the mod-8 wrap.
    always_comb begin
        idx_m2 = lane_idx_q - 3'd2;
        idx_m1 = lane_idx_q - 3'd1;
        idx_p1 = lane_idx_q + 3'd1;
        idx_p2 = lane_idx_q + 3'd2;
        idx_p3 = lane_idx_q + 3'd3;
        idx_p4 = lane_idx_q + 3'd4;
        idx_p5 = lane_idx_q + 3'd5;
    end

    mix_alu u_alu (
        .stage_i (stage_q),
        .idx_i   (lane_idx_q),
        .l_i     (lane_q[lane_idx_q]),
        .l_m2_i  (lane_q[idx_m2]),
        .l_m1_i  (lane_q[idx_m1]),
        .l_p1_i  (lane_q[idx_p1]),
        .l_p2_i  (lane_q[idx_p2]),
        .l_p3_i  (lane_q[idx_p3]),
        .l_p4_i  (lane_q[idx_p4]),
        .l_p5_i  (lane_q[idx_p5]),
        .l_o     (alu_out)
    );

    assign last_op = (stage_q == LastStage) && (lane_idx_q == 3'd7) && (round_q == LastRound);

    // FSM next state and microprogram counters.
    always_comb begin
        state_d    = state_q;
        stage_d    = stage_q;
        lane_idx_d = lane_idx_q;
        round_d    = round_q;
        case (state_q)
            StIdle: begin
                // A write in the same cycle wins; start is dropped, not deferred.
                if (bus.start && !bus.wr_en) begin
                    state_d    = StRun;
                    stage_d    = S0;
                    lane_idx_d = 3'd0;
                    round_d    = 8'd0;
                end
            end
            StRun: begin
                if (last_op) begin
                    state_d = StDone;
                end else if (lane_idx_q == 3'd7) begin
                    lane_idx_d = 3'd0;
                    if (stage_q == LastStage) begin
                        stage_d = S0;
                        round_d = round_q + 8'd1;
                    end else begin
                        stage_d = stage_t'(stage_q + 3'd1);
                    end
                end else begin
                    lane_idx_d = lane_idx_q + 3'd1;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Lane file next state: host writes only in idle, ALU writeback only while running.
    always_comb begin
        lane_d = lane_q;
        if (state_q == StIdle && bus.wr_en) begin
            lane_d[bus.wr_idx] = bus.wr_data;
        end else if (state_q == StRun) begin
            lane_d[lane_idx_q] = alu_out;
        end
    end

    // State, counters and lane file registers; reset seeds lane i with i.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            stage_q    <= S0;
            lane_idx_q <= 3'd0;
            round_q    <= 8'd0;
            for (int i = 0; i < N_LANES; i++) begin
                lane_q[i] <= 32'(i);
            end
        end else begin
            state_q    <= state_d;
            stage_q    <= stage_d;
            lane_idx_q <= lane_idx_d;
            round_q    <= round_d;
            lane_q     <= lane_d;
        end
    end

    // Outputs: read port is a plain mux; status decodes straight from the state.
    always_comb begin
        bus.rd_data = lane_q[bus.rd_idx];
        bus.busy    = (state_q == StRun);
        bus.done    = (state_q == StDone);
    end

endmodule

// File: tb/tb_mix_round_sequencer.sv
// Directed bench for mix_round_sequencer with a software lane model and a result scoreboard.
module tb_mix_round_sequencer;
    import mix_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst1, rst3;

    mix_round_sequencer_if if1 ();
    mix_round_sequencer_if if3 ();

    mix_round_sequencer #(.ROUNDS(1)) dut1 (.clk(clk), .rst(rst1), .bus(if1));
    mix_round_sequencer #(.ROUNDS(3)) dut3 (.clk(clk), .rst(rst3), .bus(if3));

    stage_t      a_stage;
    logic [2:0]  a_idx;
    logic [31:0] a_l, a_m2, a_m1, a_p1, a_p2, a_p3, a_p4, a_p5, a_out;

    mix_alu u_alu (
        .stage_i (a_stage),
        .idx_i   (a_idx),
        .l_i     (a_l),
        .l_m2_i  (a_m2),
        .l_m1_i  (a_m1),
        .l_p1_i  (a_p1),
        .l_p2_i  (a_p2),
        .l_p3_i  (a_p3),
        .l_p4_i  (a_p4),
        .l_p5_i  (a_p5),
        .l_o     (a_out)
    );

    int          n_err = 0;
    int          n_chk = 0;
    logic [31:0] sb [$];
    logic [31:0] mdl [8];
    int unsigned ma [8] = '{2, 3, 5, 7, 11, 13, 17, 19};
    int unsigned mb [8] = '{3, 5, 7, 11, 13, 17, 19, 23};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] model_op(int s, int i);
        logic [31:0] li;
        li = mdl[i];
        case (s)
            0: return li + 32'(i);
            1: return li + mdl[(i + 7) % 8];
            2: return li + mdl[(i + 1) % 8] - mdl[(i + 5) % 8];
            3: return li ^ {mdl[(i + 3) % 8][15:0], 16'h0000};
            4: return li - {17'd0, mdl[(i + 2) % 8][31:17]} + {12'd0, mdl[(i + 4) % 8][31:12]};
            5: return li + mdl[(i + 7) % 8] - mdl[(i + 6) % 8];
            default: return li * ma[i] + mb[i];
        endcase
    endfunction

    task automatic model_rounds(input int r);
        for (int rr = 0; rr < r; rr++)
            for (int s = 0; s < 7; s++)
                for (int i = 0; i < 8; i++)
                    mdl[i] = model_op(s, i);
    endtask

    task automatic push_model();
        for (int i = 0; i < 8; i++) sb.push_back(mdl[i]);
    endtask

    task automatic pop_check1(input string tag);
        for (int i = 0; i < 8; i++) begin
            if1.rd_idx = 3'(i);
            #1;
            if (sb.size() == 0) chk({tag, "_sb_empty"}, if1.rd_data, 32'hFFFF_FFFF);
            else chk(tag, if1.rd_data, sb.pop_front());
        end
    endtask

    // Start a run on dut1 and watch busy/done for a bounded window; optional stray requests.
    task automatic run1(input int n, input bit poke, output int done_cyc,
                        output int busy_cnt, output int done_cnt);
        done_cyc = 0; busy_cnt = 0; done_cnt = 0;
        if1.start = 1'b1;
        tick();
        if1.start = 1'b0;
        for (int c = 1; c <= n + 10; c++) begin
            if (if1.busy) busy_cnt++;
            if (if1.done) begin
                done_cnt++;
                if (done_cyc == 0) done_cyc = c;
            end
            if1.start   = poke && (c == 10);
            if1.wr_en   = poke && (c == 20);
            if1.wr_idx  = 3'd3;
            if1.wr_data = 32'hDEAD_BEEF;
            tick();
        end
        if1.start = 1'b0;
        if1.wr_en = 1'b0;
    endtask

    int dc, bc, dn;

    initial begin
        rst1 = 1'b1; rst3 = 1'b1;
        if1.start = 0; if1.wr_en = 0; if1.wr_idx = 0; if1.wr_data = 0; if1.rd_idx = 0;
        if3.start = 0; if3.wr_en = 0; if3.wr_idx = 0; if3.wr_data = 0; if3.rd_idx = 0;
        a_stage = S0; a_idx = 0; a_l = 0; a_m2 = 0; a_m1 = 0;
        a_p1 = 0; a_p2 = 0; a_p3 = 0; a_p4 = 0; a_p5 = 0;
        tick();
        tick();
        rst1 = 1'b0; rst3 = 1'b0;

        // Reset state.
        for (int i = 0; i < 8; i++) begin
            if1.rd_idx = 3'(i);
            #1;
            chk("reset_rd", if1.rd_data, 32'(i));
        end
        chk("reset_busy", {31'd0, if1.busy}, 32'd0);
        chk("reset_done", {31'd0, if1.done}, 32'd0);

        // ALU unit checks.
        a_stage = S6; a_idx = 3'd7; a_l = 32'd1;
        #1 chk("alu_s6", a_out, 32'd42);
        a_stage = S3; a_idx = 3'd0; a_l = 32'd0; a_p3 = 32'h0000_ABCD;
        #1 chk("alu_s3", a_out, 32'hABCD_0000);
        a_stage = S4; a_idx = 3'd0; a_l = 32'd0; a_p2 = 32'h8000_0000; a_p4 = 32'd0;
        #1 chk("alu_s4", a_out, 32'hFFFF_C000);

        // ROUNDS=1 from all-zero lanes, with stray start and write mid-run.
        for (int i = 0; i < 8; i++) begin
            if1.wr_en = 1'b1; if1.wr_idx = 3'(i); if1.wr_data = 32'd0;
            tick();
        end
        if1.wr_en = 1'b0;
        if1.rd_idx = 3'd7;
        #1 chk("write_latency", if1.rd_data, 32'd0);
        for (int i = 0; i < 8; i++) mdl[i] = 32'd0;
        model_rounds(1);
        push_model();
        run1(56, 1'b1, dc, bc, dn);
        chk("r1_busy_cycles", 32'(bc), 32'd56);
        chk("r1_done_cycle", 32'(dc), 32'd57);
        chk("r1_done_count", 32'(dn), 32'd1);
        pop_check1("r1_lane");

        // ROUNDS=3 from reset seeds on the second instance.
        for (int i = 0; i < 8; i++) mdl[i] = 32'(i);
        model_rounds(3);
        push_model();
        dc = 0; bc = 0; dn = 0;
        if3.start = 1'b1;
        tick();
        if3.start = 1'b0;
        for (int c = 1; c <= 168 + 10; c++) begin
            if (if3.busy) bc++;
            if (if3.done) begin
                dn++;
                if (dc == 0) dc = c;
            end
            tick();
        end
        chk("r3_busy_cycles", 32'(bc), 32'd168);
        chk("r3_done_cycle", 32'(dc), 32'd169);
        chk("r3_done_count", 32'(dn), 32'd1);
        for (int i = 0; i < 8; i++) begin
            if3.rd_idx = 3'(i);
            #1;
            if (sb.size() == 0) chk("r3_sb_empty", if3.rd_data, 32'hFFFF_FFFF);
            else chk("r3_lane", if3.rd_data, sb.pop_front());
        end

        // Write and start together: write lands, start is dropped.
        if1.wr_en = 1'b1; if1.wr_idx = 3'd5; if1.wr_data = 32'h1234_5678; if1.start = 1'b1;
        tick();
        if1.wr_en = 1'b0; if1.start = 1'b0;
        chk("wr_start_busy", {31'd0, if1.busy}, 32'd0);
        if1.rd_idx = 3'd5;
        #1 chk("wr_start_data", if1.rd_data, 32'h1234_5678);
        tick();
        chk("wr_start_still_idle", {31'd0, if1.busy}, 32'd0);

        // Reset at cycle 30 of a run.
        if1.start = 1'b1;
        tick();
        if1.start = 1'b0;
        dn = 0;
        for (int c = 1; c < 30; c++) begin
            if (if1.done) dn++;
            tick();
        end
        chk("mid_busy_before_rst", {31'd0, if1.busy}, 32'd1);
        rst1 = 1'b1;
        tick();
        rst1 = 1'b0;
        chk("rst_mid_busy", {31'd0, if1.busy}, 32'd0);
        chk("rst_mid_done", {31'd0, if1.done}, 32'd0);
        for (int i = 0; i < 8; i++) begin
            if1.rd_idx = 3'(i);
            #1;
            chk("rst_mid_lane", if1.rd_data, 32'(i));
        end
        for (int c = 0; c < 3; c++) begin
            if (if1.done) dn++;
            tick();
        end
        chk("rst_mid_no_done", 32'(dn), 32'd0);

        // Restart after the mid-run reset runs to completion from the seeds.
        for (int i = 0; i < 8; i++) mdl[i] = 32'(i);
        model_rounds(1);
        push_model();
        run1(56, 1'b0, dc, bc, dn);
        chk("restart_busy_cycles", 32'(bc), 32'd56);
        chk("restart_done_cycle", 32'(dc), 32'd57);
        chk("restart_done_count", 32'(dn), 32'd1);
        pop_check1("restart_lane");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
